// File: rtl/inst_fetch_unit_if.sv
// Instruction memory read port shared between the fetch unit and memory.
//   mem_req   : read request, held high while the fetch waits
//   mem_addr  : word-aligned byte address, stable while mem_req is high
//   mem_ready : read-data-valid from memory
//   mem_rdata : read data returned by memory
// master = fetch unit side, slave = memory side.
interface inst_fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues one instruction-memory read
// per fetch request, loads IR and pulses W_IR_valid when the read completes.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   write_ir     : fetch request (level; one fetch per IDLE visit)
//   write_pc     : PC update strobe, source selected by pc_s
//   pc_s         : 00 = PC+4 (only when the fetch completes), 01 = B, 10 = F
//   B, F         : branch targets (low two bits forced to zero)
//   mem          : instruction memory read port (master side)
//   IR           : instruction register
//   W_IR_valid   : one-cycle pulse when IR holds a new instruction
//   PC           : current program counter
//   fetch_err    : sticky memory-timeout flag, cleared only by rst
module inst_fetch_unit (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      write_ir,
  input  logic                      write_pc,
  input  logic [1:0]                pc_s,
  input  logic [31:0]               B,
  input  logic [31:0]               F,
  inst_fetch_unit_if.master         mem,
  output logic [31:0]               IR,
  output logic                      W_IR_valid,
  output logic [31:0]               PC,
  output logic                      fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic        err_q, err_d;
  logic        flush_q, flush_d;
  logic [7:0]  wcnt_q, wcnt_d;

  logic        redirect;
  logic [31:0] redir_src;

  assign redirect  = write_pc && ((pc_s == 2'b01) || (pc_s == 2'b10));
  assign redir_src = (pc_s == 2'b01) ? B : F;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    addr_d  = addr_q;
    req_d   = req_q;
    err_d   = err_q;
    flush_d = flush_q;
    wcnt_d  = wcnt_q;

    case (state_q)
      IDLE: begin
        if (write_ir && !err_q) begin
          state_d = WAIT;
          addr_d  = pc_q;
          req_d   = 1'b1;
          wcnt_d  = '0;
          flush_d = 1'b0;
        end
      end
      WAIT: begin
        if (redirect) flush_d = 1'b1;
        if (mem.mem_ready) begin
          req_d   = 1'b0;
          flush_d = 1'b0;
          // A redirect in this very cycle also counts as a pending flush,
          // so the response never lands in IR after the PC has moved.
          if (flush_q || redirect) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
            ir_d    = mem.mem_rdata;
          end
        end else if (wcnt_q == 8'd254) begin
          // This edge brings the counter to 255: give up on the read.
          wcnt_d  = 8'd255;
          err_d   = 1'b1;
          req_d   = 1'b0;
          flush_d = 1'b0;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (redirect) begin
      pc_d = {redir_src[31:2], 2'b00};
    end else if (write_pc && (pc_s == 2'b00) && (state_q == WAIT) && (state_d == DONE)) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      flush_q <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      err_q   <= err_d;
      flush_q <= flush_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;
  assign IR           = ir_q;
  assign W_IR_valid   = (state_q == DONE);
  assign PC           = pc_q;
  assign fetch_err    = err_q;

endmodule
